logicnet_input_quantizer: RTL and testbench
===========================================

# logicnet_input_quantizer

Streaming front end of the LogicNet classifier. It accepts raw signed feature words one per beat over a valid/ready stream and quantizes each word to a 2-bit code against per-feature thresholds. It packs one frame of codes into the flat input vector consumed by the layer-0 neuron LUT modules, and presents that vector on a valid/ready output held stable until taken.

## Interface
Parameters:
- NUM_FEATURES, 49: features per frame; must be ≥2.
- FEAT_W, 16: width of the signed raw feature word.
- IN_BITS, 2: code width per feature; fixed at 2, with 3 thresholds per feature.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- s_valid, input, 1: raw feature beat valid.
- s_ready, output, 1: block can accept a beat.
- s_data, input, FEAT_W: signed raw feature value.
- s_last, input, 1: marks the final feature of a frame.
- m_valid, output, 1: packed vector valid.
- m_ready, input, 1: downstream (layer 0) accepts the vector.
- m_data, output, NUM_FEATURES*IN_BITS: packed codes; feature k occupies bits [2k+1:2k].
- err_frame, output, 1: one-cycle pulse when a frame is dropped because of a framing error.

## Operation
- Handshakes:
  - Input beat transfers when s_valid && s_ready.
  - Output transfers when m_valid && m_ready.
- Feature index counter idx runs 0..NUM_FEATURES-1; the thresholds used for a beat are selected by idx.
- Quantization, with signed compares and thresholds ordered t0 ≤ t1 ≤ t2: code = (s_data ≥ t0) + (s_data ≥ t1) + (s_data ≥ t2), giving a value in 0..3.
- Each accepted code is written into the assembly register at slot idx.
- States:
  - COLLECT: s_ready=1. On each accepted beat:
    - idx < NUM_FEATURES-1 and s_last=0: idx++.
    - idx == NUM_FEATURES-1 and s_last=1: copy the assembly register, including the current code, to the output register; idx←0; go to PRESENT.
    - Mismatch (s_last=1 early, or s_last=0 at the final index): discard the frame; idx←0; pulse err_frame the next cycle; stay in COLLECT.
  - PRESENT: m_valid=1, s_ready=0. On m_ready, go to COLLECT.
- m_data changes only on entry to PRESENT. It is stable while m_valid=1 and m_ready=0.
- Slots of a discarded frame are not cleared. Every slot is overwritten by the next complete frame before it is presented.

## Timing
- Reset values: s_ready=0 during the reset cycle, then 1. Also m_valid=0, m_data=0, err_frame=0, idx=0, state COLLECT.
- Latency: the final beat accepted in cycle t gives m_valid=1 in cycle t+1.
- s_ready is a registered function of state. It has no combinational path from m_ready.
- With m_ready held high, m_valid lasts exactly one cycle, and the first beat of the next frame is accepted at t+2. Minimum frame period is NUM_FEATURES+1 cycles.
- err_frame asserts in cycle t+1 after the offending beat at t, for exactly one cycle.
- Reset mid-frame or mid-PRESENT discards all partial and pending data. No m_valid is produced.
- s_data and s_last are ignored when s_valid=0.

## Structure
- Shared package logicnet_pkg holds:
  - IN_BITS and FEAT_W constants.
  - typedef feat_t (signed FEAT_W).
  - typedef code_t (2 bits).
  - Threshold table type and the generated per-feature threshold constant array.
  - State enum {COLLECT, PRESENT}.
- One sub-module, logicnet_feature_threshold. It is purely combinational, maps (idx, feat_t) to code_t, and is sourced from the generated threshold array.
- Top contains the FSM, index counter, assembly register and output register.

## Test plan
Bench configuration: NUM_FEATURES=4, all thresholds {-256, 0, 256}.
- Frame {-300, -1, 100, 300} with s_last on beat 3 and m_ready=1 → m_data=8'b11_10_01_00, m_valid for 1 cycle at t+1.
- Same frame with m_ready=0 for 5 cycles → m_valid and m_data held; s_ready=0 throughout; release at m_ready=1.
- Boundary values {-256, 0, 256, 32767} → codes {1, 2, 3, 3}, m_data=8'b11_11_10_01. Value -32768 → code 0.
- s_last on beat 1 → err_frame pulse, no m_valid. The following good frame {300,300,300,300} → m_data=8'hFF.
- No s_last on beat 3 → err_frame pulse, frame dropped, idx back to 0.
- rst asserted after 2 beats → no output. The next 4-beat frame produces correct m_data; back-to-back frames sustain one vector per 5 cycles.

Source files
------------

// File: rtl/logicnet_input_quantizer_pkg.sv
// Shared types and constants for the LogicNet input quantizer: feature/code
// types, the per-feature threshold table and the frame FSM state encoding.
package logicnet_pkg;

   localparam int FEAT_W       = 16;
   localparam int IN_BITS      = 2;
   localparam int MAX_FEATURES = 49;

   typedef logic signed [FEAT_W-1:0] feat_t;
   typedef logic [IN_BITS-1:0]       code_t;

   // Three ordered thresholds per feature: t0 <= t1 <= t2.
   typedef struct packed {
      feat_t t2;
      feat_t t1;
      feat_t t0;
   } thr_t;

   typedef thr_t [MAX_FEATURES-1:0] thr_tab_t;

   typedef enum logic {
      COLLECT = 1'b0,
      PRESENT = 1'b1
   } state_t;

   // Builds the threshold table; every feature currently shares the
   // symmetric split {-256, 0, 256} around zero.
   function automatic thr_tab_t gen_thresholds();
      thr_tab_t tab;
      for (int k = 0; k < MAX_FEATURES; k++) begin
         tab[k].t0 = -16'sd256;
         tab[k].t1 = 16'sd0;
         tab[k].t2 = 16'sd256;
      end
      return tab;
   endfunction

   localparam thr_tab_t THRESH_TAB = gen_thresholds();

endpackage

// File: rtl/logicnet_feature_threshold.sv
// Combinational per-feature quantizer: looks up the three thresholds of
// feature idx_i and counts how many of them the signed input reaches.
module logicnet_feature_threshold
   import logicnet_pkg::*;
#(
   parameter int IDX_W = 6
) (
   input  logic [IDX_W-1:0] idx_i,
   input  feat_t            feat_i,
   output code_t            code_o
);

   localparam int TAB_IW = $clog2(MAX_FEATURES);

   logic [TAB_IW-1:0] tab_idx_s;
   thr_t              thr_s;
   logic              ge0_s;
   logic              ge1_s;
   logic              ge2_s;

   // Threshold lookup and signed compare; code is the number of thresholds met.
   always_comb begin
      tab_idx_s = TAB_IW'(idx_i);
      thr_s     = THRESH_TAB[tab_idx_s];
      ge0_s     = ($signed(feat_i) >= $signed(thr_s.t0));
      ge1_s     = ($signed(feat_i) >= $signed(thr_s.t1));
      ge2_s     = ($signed(feat_i) >= $signed(thr_s.t2));
      code_o    = code_t'(ge0_s) + code_t'(ge1_s) + code_t'(ge2_s);
   end

endmodule

// File: rtl/logicnet_input_quantizer.sv
// Streaming front end: quantizes one feature per beat, assembles a frame of
// 2-bit codes and presents the packed vector until downstream takes it.
// Frames whose s_last does not line up with the final index are dropped.
module logicnet_input_quantizer #(
   parameter int NUM_FEATURES = 49,
   parameter int FEAT_W       = 16,
   parameter int IN_BITS      = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic signed [FEAT_W-1:0]        s_data,
   input  logic                            s_last,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [NUM_FEATURES*IN_BITS-1:0] m_data,
   output logic                            err_frame
);

   import logicnet_pkg::*;

   localparam int IDX_W = $clog2(NUM_FEATURES);
   localparam int VEC_W = NUM_FEATURES * IN_BITS;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [VEC_W-1:0]  asm_q, asm_d;
   logic [VEC_W-1:0]  data_q, data_d;
   logic              s_ready_q, s_ready_d;
   logic              err_q, err_d;
   logic [VEC_W-1:0]  asm_wr_s;
   code_t             code_s;
   logic              accept_s;
   logic              last_idx_s;

   logicnet_feature_threshold #(
      .IDX_W (IDX_W)
   ) u_thr (
      .idx_i  (idx_q),
      .feat_i (feat_t'(s_data)),
      .code_o (code_s)
   );

   // Assembly register with the current beat's code merged into slot idx.
   always_comb begin
      accept_s   = s_valid && s_ready_q;
      last_idx_s = (idx_q == IDX_W'(NUM_FEATURES - 1));
      asm_wr_s   = asm_q;
      for (int k = 0; k < NUM_FEATURES; k++) begin
         if (idx_q == IDX_W'(k)) begin
            asm_wr_s[k*IN_BITS +: IN_BITS] = code_s;
         end else begin
            asm_wr_s[k*IN_BITS +: IN_BITS] = asm_q[k*IN_BITS +: IN_BITS];
         end
      end
   end

   // Frame FSM: index stepping, framing check, hand-off to the output register.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      asm_d   = asm_q;
      data_d  = data_q;
      err_d   = 1'b0;
      case (state_q)
         COLLECT: begin
            if (accept_s) begin
               if (s_last && last_idx_s) begin
                  asm_d   = asm_wr_s;
                  data_d  = asm_wr_s;
                  idx_d   = '0;
                  state_d = PRESENT;
               end else if (!s_last && !last_idx_s) begin
                  asm_d = asm_wr_s;
                  idx_d = idx_q + IDX_W'(1);
               end else begin
                  // Framing mismatch: drop the frame, stale slots are
                  // overwritten by the next complete frame anyway.
                  idx_d = '0;
                  err_d = 1'b1;
               end
            end else begin
               state_d = COLLECT;
            end
         end
         PRESENT: begin
            if (m_ready) begin
               state_d = COLLECT;
            end else begin
               state_d = PRESENT;
            end
         end
         default: begin
            state_d = COLLECT;
            idx_d   = '0;
         end
      endcase
      s_ready_d = (state_d == COLLECT);
   end

   // State, counter and data registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= COLLECT;
         idx_q     <= '0;
         asm_q     <= '0;
         data_q    <= '0;
         s_ready_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         asm_q     <= asm_d;
         data_q    <= data_d;
         s_ready_q <= s_ready_d;
         err_q     <= err_d;
      end
   end

   assign s_ready   = s_ready_q;
   assign m_valid   = (state_q == PRESENT);
   assign m_data    = data_q;
   assign err_frame = err_q;

endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// Self-checking bench for logicnet_input_quantizer with NUM_FEATURES=4.
// Expected codes come from a plain arithmetic threshold-count model.
module tb_logicnet_input_quantizer;

   localparam int NF = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              s_valid;
   logic              s_ready;
   logic signed [15:0] s_data;
   logic              s_last;
   logic              m_valid;
   logic              m_ready;
   logic [2*NF-1:0]   m_data;
   logic              err_frame;

   int checks   = 0;
   int failures = 0;
   int cyc_cnt  = 0;

   always #5 clk = ~clk;

   // free-running cycle counter for throughput measurement
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   logicnet_input_quantizer #(
      .NUM_FEATURES (NF),
      .FEAT_W       (16),
      .IN_BITS      (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .err_frame (err_frame)
   );

   function automatic int ref_code(int v);
      int c;
      c = 0;
      if (v >= -256) c = c + 1;
      if (v >= 0)    c = c + 1;
      if (v >= 256)  c = c + 1;
      return c;
   endfunction

   function automatic logic [7:0] ref_pack(int v[4]);
      logic [7:0] r;
      r = 8'h00;
      for (int k = 0; k < NF; k++) begin
         r = r | (8'(ref_code(v[k])) << (2 * k));
      end
      return r;
   endfunction

   function automatic int rand_feat();
      if ($urandom_range(0, 1) == 0) begin
         return int'($signed(16'($urandom)));
      end else begin
         return -300 + int'($urandom_range(0, 600));
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One beat offered at a negedge, taken at the following posedge.
   task automatic beat(input int v, input logic last);
      chk("s_ready_at_beat", 32'(s_ready), 32'd1);
      s_valid = 1'b1;
      s_data  = 16'(v);
      s_last  = last;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 16'($urandom);
      @(negedge clk);
   endtask

   task automatic frame(input int v[4]);
      for (int k = 0; k < NF; k++) begin
         beat(v[k], (k == NF - 1));
      end
   endtask

   // Checks the presented vector, optionally stalls, then releases it.
   task automatic present(input logic [7:0] exp, input int stall, input string tag);
      chk({tag, "_m_valid"}, 32'(m_valid), 32'd1);
      chk({tag, "_m_data"}, 32'(m_data), 32'(exp));
      chk({tag, "_s_ready_low"}, 32'(s_ready), 32'd0);
      if (stall > 0) m_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         s_valid = 1'b1;
         s_data  = 16'($urandom);
         s_last  = 1'($urandom);
         @(negedge clk);
         chk({tag, "_hold_valid"}, 32'(m_valid), 32'd1);
         chk({tag, "_hold_data"}, 32'(m_data), 32'(exp));
         chk({tag, "_hold_s_ready"}, 32'(s_ready), 32'd0);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_released"}, 32'(m_valid), 32'd0);
      chk({tag, "_s_ready_back"}, 32'(s_ready), 32'd1);
   endtask

   initial begin
      int fv[4];
      int t_prev;
      rst     = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 16'sd0;
      m_ready = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_err", 32'(err_frame), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_s_ready", 32'(s_ready), 32'd1);

      // basic frame, one-cycle m_valid
      fv = '{-300, -1, 100, 300};
      frame(fv);
      chk("basic_lit", 32'(m_data), 32'h0000_00E4);
      present(ref_pack(fv), 0, "basic");

      // same frame with 5-cycle backpressure
      frame(fv);
      present(8'hE4, 5, "stall");

      // boundary values
      fv = '{-256, 0, 256, 32767};
      frame(fv);
      chk("bound_lit", 32'(m_data), 32'h0000_00F9);
      present(ref_pack(fv), 0, "bound");
      fv = '{-32768, -257, 255, 256};
      frame(fv);
      chk("min_lit", 32'(m_data), 32'h0000_00E0);
      present(ref_pack(fv), 0, "min");

      // early s_last on beat 1
      beat(500, 1'b0);
      beat(500, 1'b1);
      chk("early_err", 32'(err_frame), 32'd1);
      chk("early_no_valid", 32'(m_valid), 32'd0);
      @(negedge clk);
      chk("early_err_end", 32'(err_frame), 32'd0);
      chk("early_no_valid2", 32'(m_valid), 32'd0);
      fv = '{300, 300, 300, 300};
      frame(fv);
      chk("after_early_lit", 32'(m_data), 32'h0000_00FF);
      present(ref_pack(fv), 0, "after_early");

      // missing s_last on final beat
      for (int k = 0; k < NF; k++) beat(-1000, 1'b0);
      chk("late_err", 32'(err_frame), 32'd1);
      chk("late_no_valid", 32'(m_valid), 32'd0);
      @(negedge clk);
      chk("late_err_end", 32'(err_frame), 32'd0);
      fv = '{0, -300, 256, -1};
      frame(fv);
      present(ref_pack(fv), 0, "after_late");

      // reset mid-frame
      beat(300, 1'b0);
      beat(300, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_s_ready", 32'(s_ready), 32'd0);
      chk("midrst_m_valid", 32'(m_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_no_valid", 32'(m_valid), 32'd0);
      for (int k = 0; k < NF; k++) fv[k] = rand_feat();
      frame(fv);
      present(ref_pack(fv), 0, "post_midrst");

      // back-to-back frames, one vector per NF+1 cycles
      t_prev = 0;
      for (int f = 0; f < 4; f++) begin
         for (int k = 0; k < NF; k++) fv[k] = rand_feat();
         frame(fv);
         if (f > 0) chk("b2b_period", 32'(cyc_cnt - t_prev), 32'(NF + 1));
         t_prev = cyc_cnt;
         present(ref_pack(fv), 0, "b2b");
      end

      // random frames with random stalls
      for (int f = 0; f < 10; f++) begin
         for (int k = 0; k < NF; k++) fv[k] = rand_feat();
         frame(fv);
         present(ref_pack(fv), int'($urandom_range(0, 3)), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
